cvxif_issue_arbiter: RTL and testbench
======================================

Name: cvxif_issue_arbiter

Overview:
Shares one CV-X-IF coprocessor between NrPorts cva6 harts. Round-robin arbitration on the issue channel, with a grant lock while the coprocessor back-pressures. The winning port index is prepended to the instruction ID so results route back to the issuing hart. A per-port outstanding-instruction counter caps in-flight work.

Parameters:
NrPorts, 2, number of requesting harts (>=2)
IdWidth, 3, per-hart instruction ID width
XLen, 64, operand/result data width
MaxOutstanding, 4, max in-flight issued-but-unresolved instructions per port (>=1)
Derived: PortW = $clog2(NrPorts); CntW = $clog2(MaxOutstanding+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  NrPorts  per-port issue request
issue_ready_o  out  NrPorts  per-port issue accept
issue_instr_i  in  NrPorts*32  per-port instruction word
issue_id_i  in  NrPorts*IdWidth  per-port instruction ID
issue_rs_i  in  NrPorts*2*XLen  per-port rs1/rs2 operands (rs1 in low half)
x_issue_valid_o  out  1  to coprocessor
x_issue_ready_i  in  1  from coprocessor
x_issue_instr_o  out  32  granted instruction
x_issue_id_o  out  PortW+IdWidth  {port index, ID}
x_issue_rs_o  out  2*XLen  granted operands
x_result_valid_i  in  1  coprocessor result valid
x_result_ready_o  out  1  result accept
x_result_id_i  in  PortW+IdWidth  tagged result ID
x_result_data_i  in  XLen  result data
result_valid_o  out  NrPorts  per-port result valid
result_ready_i  in  NrPorts  per-port result accept
result_id_o  out  IdWidth  untagged ID, broadcast
result_data_o  out  XLen  result data, broadcast
outstanding_o  out  NrPorts*CntW  per-port in-flight count
idle_o  out  1  FSM IDLE and all counters zero
err_bad_port_o  out  1  one-cycle pulse on result with port index >= NrPorts

Behaviour:
- Reset: FSM=IDLE, rr_ptr=0, locked grant=0, counters=0. All valid/ready outputs 0, idle_o=1, err_bad_port_o=0. Reset mid-transaction discards it; no replay.
- Eligibility: eligible[i] = issue_valid_i[i] && cnt[i] < MaxOutstanding.
- IDLE: winner = first eligible port scanning rr_ptr, rr_ptr+1, ... modulo NrPorts. Data path is combinational, zero latency: x_issue_valid_o=1 and x_issue_* = winner's fields in the same cycle.
  - Handshake (x_issue_ready_i=1): stay IDLE; rr_ptr <= winner+1 (wraps NrPorts-1 -> 0); cnt[winner]++.
  - No ready: latch winner, go LOCKED.
- LOCKED: drive only the latched port, ignore other requesters. Requesters hold valid and payload stable until ready (AXI rule; violation is undefined). On handshake: cnt++, rr_ptr <= grant+1, go IDLE.
- issue_ready_o[i] = x_issue_valid_o && x_issue_ready_i && grant==i. All other bits 0.
- No eligible port: x_issue_valid_o=0 and x_issue_* driven 0.
- Result path, purely combinational, no buffering:
  - p = x_result_id_i[IdWidth +: PortW].
  - p < NrPorts: result_valid_o[p] = x_result_valid_i, other bits 0; x_result_ready_o = result_ready_i[p]. On handshake, cnt[p]--.
  - p >= NrPorts: drop with x_result_ready_o=1; err_bad_port_o=1 for that cycle; no counter change.
- Same-cycle issue and result handshake on one port: counter unchanged.
- Decrement at 0 is an error: counter saturates at 0 and err_bad_port_o pulses.
- Counter at MaxOutstanding blocks that port only; the others continue.

Test Plan:
- Reset: assert rst_ni=0 mid-LOCKED -> all outputs 0, idle_o=1; after release, port 0 wins first.
- Fairness: NrPorts=2, both valid, ready=1 always -> grants alternate 0,1,0,1; x_issue_id_o MSB alternates.
- Lock: port1 granted with ready=0 for 3 cycles while port0 also valid -> x_issue_instr_o stays port1's word; port0 granted on the cycle after the handshake.
- Cap: MaxOutstanding=4, port0 issues 4 with no results -> 5th blocked, outstanding_o[0]=4; one result with id {0,3'h2} -> count 3, issue resumes.
- Routing: x_result_id_i={1,3'h5}, result_ready_i=2'b10 -> result_valid_o=2'b10, result_id_o=3'h5, x_result_ready_o=1, cnt[1] decrements.
- Simultaneous events and bad port: port0 issue and result handshake in the same cycle -> count unchanged. With NrPorts=3, a result tagged port 3 -> x_result_ready_o=1, err pulse, no valid driven.

Source files
------------

// File: rtl/cvxif_issue_arbiter.sv
// Shares one CV-X-IF coprocessor between NrPorts harts: round-robin issue with a
// grant lock under back-pressure, port-tagged IDs, and per-port in-flight caps.

module cvxif_issue_cnt #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntW           = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            full_o,
  output logic            uflow_o
);
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    uflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (32'(cnt_q) < MaxOutstanding) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      // a result with nothing outstanding is flagged and the count stays at 0
      if (cnt_q == '0) uflow_o = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign full_o = (32'(cnt_q) >= MaxOutstanding);
endmodule

module cvxif_issue_arbiter #(
  parameter  int unsigned NrPorts        = 2,
  parameter  int unsigned IdWidth        = 3,
  parameter  int unsigned XLen           = 64,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned PortW          = $clog2(NrPorts),
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NrPorts-1:0]                issue_valid_i,
  output logic [NrPorts-1:0]                issue_ready_o,
  input  logic [NrPorts-1:0][31:0]          issue_instr_i,
  input  logic [NrPorts-1:0][IdWidth-1:0]   issue_id_i,
  input  logic [NrPorts-1:0][2*XLen-1:0]    issue_rs_i,
  output logic                              x_issue_valid_o,
  input  logic                              x_issue_ready_i,
  output logic [31:0]                       x_issue_instr_o,
  output logic [PortW+IdWidth-1:0]          x_issue_id_o,
  output logic [2*XLen-1:0]                 x_issue_rs_o,
  input  logic                              x_result_valid_i,
  output logic                              x_result_ready_o,
  input  logic [PortW+IdWidth-1:0]          x_result_id_i,
  input  logic [XLen-1:0]                   x_result_data_i,
  output logic [NrPorts-1:0]                result_valid_o,
  input  logic [NrPorts-1:0]                result_ready_i,
  output logic [IdWidth-1:0]                result_id_o,
  output logic [XLen-1:0]                   result_data_o,
  output logic [NrPorts-1:0][CntW-1:0]      outstanding_o,
  output logic                              idle_o,
  output logic                              err_bad_port_o
);
  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic [31:0]        instr;
    logic [IdWidth-1:0] id;
    logic [2*XLen-1:0]  rs;
  } issue_req_t;

  state_e                        state_q, state_d;
  logic [PortW-1:0]              rr_ptr_q, rr_ptr_d, grant_q, grant_d, grant, win_idx, rr_next;
  logic                          win_vld, issue_hs, bad_port, err_port;
  logic [PortW-1:0]              res_port;
  logic [NrPorts-1:0]            eligible, full, inc, dec, uflow;
  logic [NrPorts-1:0][CntW-1:0]  cnt;
  issue_req_t [NrPorts-1:0]      req;

  for (genvar i = 0; i < NrPorts; i++) begin : g_port
    assign req[i]      = '{instr: issue_instr_i[i], id: issue_id_i[i], rs: issue_rs_i[i]};
    assign eligible[i] = issue_valid_i[i] && !full[i];

    cvxif_issue_cnt #(
      .MaxOutstanding (MaxOutstanding),
      .CntW           (CntW)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (inc[i]),
      .dec_i   (dec[i]),
      .cnt_o   (cnt[i]),
      .full_o  (full[i]),
      .uflow_o (uflow[i])
    );
  end

  // scan downward so the last hit is the first eligible port at or after rr_ptr
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NrPorts - 1; k >= 0; k--) begin
      int unsigned s;
      s = 32'(rr_ptr_q) + 32'(k);
      if (s >= NrPorts) s = s - NrPorts;
      if (eligible[s]) begin
        win_vld = 1'b1;
        win_idx = PortW'(s);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    issue_ready_o   = '0;
    inc             = '0;
    grant           = (state_q == LOCKED) ? grant_q : win_idx;
    rr_next         = (32'(grant) == NrPorts - 1) ? '0 : grant + 1'b1;
    x_issue_valid_o = rst_ni && ((state_q == LOCKED) ? issue_valid_i[grant_q] : win_vld);
    x_issue_instr_o = '0;
    x_issue_id_o    = '0;
    x_issue_rs_o    = '0;
    if (x_issue_valid_o) begin
      x_issue_instr_o = req[grant].instr;
      x_issue_id_o    = {grant, req[grant].id};
      x_issue_rs_o    = req[grant].rs;
    end
    issue_hs = x_issue_valid_o && x_issue_ready_i;
    if (issue_hs) begin
      issue_ready_o[grant] = 1'b1;
      inc[grant]           = 1'b1;
      rr_ptr_d             = rr_next;
      state_d              = IDLE;
    end else if (state_q == IDLE && win_vld) begin
      // coprocessor stalled: hold this port until it is accepted
      state_d = LOCKED;
      grant_d = win_idx;
    end
  end

  always_comb begin
    res_port         = x_result_id_i[IdWidth +: PortW];
    bad_port         = (32'(res_port) >= NrPorts);
    result_valid_o   = '0;
    x_result_ready_o = 1'b0;
    dec              = '0;
    err_port         = 1'b0;
    if (rst_ni) begin
      if (bad_port) begin
        x_result_ready_o = 1'b1;
        err_port         = x_result_valid_i;
      end else begin
        result_valid_o[res_port] = x_result_valid_i;
        x_result_ready_o         = result_ready_i[res_port];
        dec[res_port]            = x_result_valid_i && result_ready_i[res_port];
      end
    end
  end

  assign result_id_o    = x_result_id_i[IdWidth-1:0];
  assign result_data_o  = x_result_data_i;
  assign outstanding_o  = cnt;
  assign idle_o         = (state_q == IDLE) && (cnt == '0);
  assign err_bad_port_o = err_port || (|uflow);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end
endmodule

// File: tb/tb_cvxif_issue_arbiter.sv
// Directed bench for cvxif_issue_arbiter: a 2-port instance for arbitration,
// locking, capping and routing, and a 3-port instance for the bad-port tag.

module tb_cvxif_issue_arbiter;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  // 2-port instance
  logic [1:0]         iv, ir, rv, rr;
  logic [1:0][31:0]   instr;
  logic [1:0][2:0]    iid;
  logic [1:0][127:0]  rs;
  logic               xiv, xir, xrv, xrr, err;
  logic [31:0]        xinstr;
  logic [3:0]         xiid, xrid;
  logic [127:0]       xrs;
  logic [63:0]        xrdata, rdata;
  logic [2:0]         rid;
  logic [1:0][2:0]    outs;
  logic               idle;

  cvxif_issue_arbiter #(.NrPorts(2), .IdWidth(3), .XLen(64), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .issue_valid_i(iv), .issue_ready_o(ir), .issue_instr_i(instr), .issue_id_i(iid),
    .issue_rs_i(rs), .x_issue_valid_o(xiv), .x_issue_ready_i(xir), .x_issue_instr_o(xinstr),
    .x_issue_id_o(xiid), .x_issue_rs_o(xrs), .x_result_valid_i(xrv), .x_result_ready_o(xrr),
    .x_result_id_i(xrid), .x_result_data_i(xrdata), .result_valid_o(rv), .result_ready_i(rr),
    .result_id_o(rid), .result_data_o(rdata), .outstanding_o(outs), .idle_o(idle),
    .err_bad_port_o(err)
  );

  // 3-port instance
  logic [2:0]         iv3, ir3, rv3, rr3;
  logic [2:0][31:0]   instr3;
  logic [2:0][2:0]    iid3;
  logic [2:0][127:0]  rs3;
  logic               xiv3, xrv3, xrr3, err3, idle3;
  logic [31:0]        xinstr3;
  logic [4:0]         xiid3, xrid3;
  logic [127:0]       xrs3;
  logic [63:0]        rdata3;
  logic [2:0]         rid3;
  logic [2:0][2:0]    outs3;

  cvxif_issue_arbiter #(.NrPorts(3), .IdWidth(3), .XLen(64), .MaxOutstanding(4)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni),
    .issue_valid_i(iv3), .issue_ready_o(ir3), .issue_instr_i(instr3), .issue_id_i(iid3),
    .issue_rs_i(rs3), .x_issue_valid_o(xiv3), .x_issue_ready_i(1'b1), .x_issue_instr_o(xinstr3),
    .x_issue_id_o(xiid3), .x_issue_rs_o(xrs3), .x_result_valid_i(xrv3), .x_result_ready_o(xrr3),
    .x_result_id_i(xrid3), .x_result_data_i(64'h77), .result_valid_o(rv3), .result_ready_i(rr3),
    .result_id_o(rid3), .result_data_o(rdata3), .outstanding_o(outs3), .idle_o(idle3),
    .err_bad_port_o(err3)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    iv = '0; xir = 1'b0; xrv = 1'b0; xrid = '0; xrdata = 64'h0; rr = '0;
    instr[0] = 32'hA0; instr[1] = 32'hB1;
    iid[0] = 3'h1; iid[1] = 3'h2;
    rs[0] = {64'h0, 64'h1111}; rs[1] = {64'h2222, 64'h3333};
    iv3 = '0; instr3 = '0; iid3 = '0; rs3 = '0; xrv3 = 1'b0; xrid3 = '0; rr3 = '0;
    #3;
    chk("rst_idle", idle, 1);
    chk("rst_xiv", xiv, 0);
    chk("rst_outs", outs, 0);
    chk("rst_err", err, 0);
    chk("rst_idle3", idle3, 1);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // fairness: both valid, coprocessor always ready
    iv = 2'b11; xir = 1'b1; settle();
    chk("rr0_instr", xinstr, 32'hA0);
    chk("rr0_id", xiid, 4'h1);
    chk("rr0_ready", ir, 2'b01);
    tick();
    chk("rr1_instr", xinstr, 32'hB1);
    chk("rr1_id", xiid, 4'hA);
    chk("rr1_rs_lo", xrs[63:0], 64'h3333);
    chk("rr1_rs_hi", xrs[127:64], 64'h2222);
    chk("rr1_ready", ir, 2'b10);
    tick();
    chk("rr2_instr", xinstr, 32'hA0);
    tick();
    chk("rr3_instr", xinstr, 32'hB1);
    tick();
    iv = 2'b00; settle();
    chk("rr_cnt0", outs[0], 2);
    chk("rr_cnt1", outs[1], 2);
    chk("rr_xiv_off", xiv, 0);
    chk("rr_xid_zero", xiid, 0);

    // result routing
    xrv = 1'b1; xrid = 4'h0; rr = 2'b01; xrdata = 64'hDEAD; settle();
    chk("res0_valid", rv, 2'b01);
    chk("res0_xrr", xrr, 1);
    tick(); tick();
    chk("res0_cnt", outs[0], 0);
    xrid = 4'hD; rr = 2'b01; settle();
    chk("res1_notready", xrr, 0);
    chk("res1_valid_nr", rv, 2'b10);
    rr = 2'b10; settle();
    chk("res1_valid", rv, 2'b10);
    chk("res1_id", rid, 3'h5);
    chk("res1_data", rdata, 64'hDEAD);
    chk("res1_xrr", xrr, 1);
    tick();
    chk("res1_cnt", outs[1], 1);
    tick();
    chk("res1_cnt0", outs[1], 0);
    chk("res_idle", idle, 1);
    xrid = 4'h0; rr = 2'b01; settle();
    chk("uflow_err", err, 1);
    tick();
    chk("uflow_cnt", outs[0], 0);
    xrv = 1'b0; rr = 2'b00; settle();
    chk("uflow_err_off", err, 0);

    // lock: port1 wins, coprocessor stalls three cycles
    iv = 2'b01; settle();
    chk("lk_pre", xinstr, 32'hA0);
    tick();
    iv = 2'b11; xir = 1'b0; settle();
    chk("lk_c1_instr", xinstr, 32'hB1);
    chk("lk_c1_ready", ir, 2'b00);
    tick();
    chk("lk_c2_instr", xinstr, 32'hB1);
    chk("lk_c2_idle", idle, 0);
    tick();
    chk("lk_c3_instr", xinstr, 32'hB1);
    tick();
    xir = 1'b1; settle();
    chk("lk_hs_instr", xinstr, 32'hB1);
    chk("lk_hs_ready", ir, 2'b10);
    tick();
    chk("lk_next_instr", xinstr, 32'hA0);
    chk("lk_next_ready", ir, 2'b01);
    chk("lk_cnt1", outs[1], 1);
    iv = 2'b00; xir = 1'b0;

    // reset while locked on port1
    iv = 2'b01; xir = 1'b1; tick();
    iv = 2'b11; xir = 1'b0; settle();
    chk("rl_pre", xinstr, 32'hB1);
    tick();
    rst_ni = 1'b0; settle();
    chk("rl_xiv", xiv, 0);
    chk("rl_ir", ir, 0);
    chk("rl_idle", idle, 1);
    chk("rl_outs", outs, 0);
    chk("rl_xrr", xrr, 0);
    rst_ni = 1'b1; xir = 1'b1; settle();
    chk("rl_first_instr", xinstr, 32'hA0);
    chk("rl_first_id", xiid, 4'h1);
    chk("rl_first_ready", ir, 2'b01);
    iv = 2'b00; tick();

    // cap: port0 issues four with no results
    iv = 2'b01;
    for (int n = 0; n < 4; n++) begin
      settle();
      chk("cap_issue", xiv, 1);
      tick();
    end
    settle();
    chk("cap_cnt4", outs[0], 4);
    chk("cap_blocked", xiv, 0);
    chk("cap_blocked_ir", ir, 0);
    iv = 2'b11; settle();
    chk("cap_other", xinstr, 32'hB1);
    iv = 2'b00;
    xrv = 1'b1; xrid = 4'h2; rr = 2'b01; tick();
    xrv = 1'b0; settle();
    chk("cap_cnt3", outs[0], 3);
    iv = 2'b01; settle();
    chk("cap_resume", xinstr, 32'hA0);
    xrv = 1'b1; xrid = 4'h0; settle();
    chk("sim_ready", ir, 2'b01);
    tick();
    chk("sim_cnt", outs[0], 3);
    iv = 2'b00; xrv = 1'b0; rr = 2'b00;

    // 3-port instance: bad tag, then a good one
    xrv3 = 1'b1; xrid3 = {2'd3, 3'h1}; rr3 = 3'b000; settle();
    chk("bad_xrr", xrr3, 1);
    chk("bad_err", err3, 1);
    chk("bad_rv", rv3, 0);
    tick();
    chk("bad_outs", outs3, 0);
    xrid3 = {2'd2, 3'h4}; rr3 = 3'b100; settle();
    chk("p2_rv", rv3, 3'b100);
    chk("p2_err", err3, 1);
    xrv3 = 1'b0; settle();
    chk("p2_err_off", err3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
